// File: rtl/sprite_pkg.sv
// Shared types and constants for the player-sprite animator: facing directions,
// animation FSM states, WASD keycodes and the key decoder.
package sprite_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } anim_state_t;

    typedef struct packed {
        logic vld;
        dir_t dir;
    } key_dec_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam int SCREEN_W = 640;

    function automatic key_dec_t decode_key(input logic [7:0] kc);
        key_dec_t k;
        k.vld = 1'b1;
        k.dir = DIR_DOWN;
        case (kc)
            KEY_W:   k.dir = DIR_UP;
            KEY_A:   k.dir = DIR_LEFT;
            KEY_S:   k.dir = DIR_DOWN;
            KEY_D:   k.dir = DIR_RIGHT;
            default: k.vld = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/sprite_anim_fsm.sv
// Walk-cycle animator: picks facing direction from the keycode and steps the
// frame counter every FRAME_TICKS vertical-frame pulses while a move key is held.
module sprite_anim_fsm
    import sprite_pkg::*;
#(
    parameter int FRAMES_PER_DIR = 2,
    parameter int FRAME_TICKS    = 8,
    parameter int FRM_W          = (FRAMES_PER_DIR > 1) ? $clog2(FRAMES_PER_DIR) : 1,
    parameter int TICK_W         = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic             frame_start,
    input  logic [7:0]       keycode,
    output dir_t             dir,
    output logic [FRM_W-1:0] frame
);

    anim_state_t       state_q, state_d;
    dir_t              dir_q, dir_d;
    logic [FRM_W-1:0]  frame_q, frame_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    key_dec_t          key;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_DOWN;
            frame_q <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            frame_q <= frame_d;
            tick_q  <= tick_d;
        end
    end

    // Key changes take priority over frame_start so a new direction always
    // starts its walk cycle from a clean tick count.
    always_comb begin
        key     = decode_key(keycode);
        state_d = state_q;
        dir_d   = dir_q;
        frame_d = frame_q;
        tick_d  = tick_q;
        case (state_q)
            IDLE: begin
                if (key.vld) begin
                    state_d = WALK;
                    dir_d   = key.dir;
                    frame_d = '0;
                    tick_d  = '0;
                end
            end
            WALK: begin
                if (!key.vld) begin
                    state_d = IDLE;
                    frame_d = '0;
                    tick_d  = '0;
                end else if (key.dir != dir_q) begin
                    dir_d   = key.dir;
                    frame_d = '0;
                    tick_d  = '0;
                end else if (frame_start) begin
                    if (tick_q == TICK_W'(FRAME_TICKS - 1)) begin
                        tick_d  = '0;
                        frame_d = (frame_q == FRM_W'(FRAMES_PER_DIR - 1)) ? '0 : frame_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dir   = dir_q;
        frame = frame_q;
    end

endmodule

// File: rtl/sprite_animator.sv
// Player-sprite renderer: sheet ROM addressing, 2-stage pixel compositing with
// index-keyed transparency, and a once-per-frame collision-map probe.
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int          SPR_W          = 32,
    parameter int          SPR_H          = 32,
    parameter int          NUM_DIRS       = 4,
    parameter int          FRAMES_PER_DIR = 2,
    parameter int          FRAME_TICKS    = 8,
    parameter int          IDX_W          = 4,
    parameter int          TRANSP_IDX     = 0,
    parameter int          COL_IDX_W      = 7,
    parameter logic [15:0] SOLID_MASK     = 16'h4150,
    parameter int          SHEET_AW       = 13,
    parameter int          COL_AW         = 18,
    localparam int         FRM_W          = (FRAMES_PER_DIR > 1) ? $clog2(FRAMES_PER_DIR) : 1
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic [9:0]           spriteX,
    input  logic [9:0]           spriteY,
    input  logic [7:0]           keycode,
    input  logic                 blank,
    input  logic [3:0]           bg_red,
    input  logic [3:0]           bg_green,
    input  logic [3:0]           bg_blue,
    output logic [SHEET_AW-1:0]  spr_addr,
    input  logic [IDX_W-1:0]     spr_idx,
    input  logic [3:0]           spr_red,
    input  logic [3:0]           spr_green,
    input  logic [3:0]           spr_blue,
    output logic [COL_AW-1:0]    col_addr,
    input  logic [COL_IDX_W-1:0] col_idx,
    output logic [3:0]           red,
    output logic [3:0]           green,
    output logic [3:0]           blue,
    output logic                 collision,
    output logic [1:0]           anim_dir,
    output logic [FRM_W-1:0]     anim_frame
);

    dir_t             dir;
    logic [FRM_W-1:0] frame;

    sprite_anim_fsm #(
        .FRAMES_PER_DIR (FRAMES_PER_DIR),
        .FRAME_TICKS    (FRAME_TICKS),
        .FRM_W          (FRM_W)
    ) u_fsm (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .keycode     (keycode),
        .dir         (dir),
        .frame       (frame)
    );

    assign anim_dir   = dir;
    assign anim_frame = frame;

    // 11-bit bounds so a sprite near the right/bottom edge never wraps to 0.
    logic [10:0] x_lo, x_hi, y_lo, y_hi;
    logic        in_box;
    logic [9:0]  dx, dy;

    assign x_lo   = {1'b0, spriteX};
    assign y_lo   = {1'b0, spriteY};
    assign x_hi   = x_lo + 11'(SPR_W - 1);
    assign y_hi   = y_lo + 11'(SPR_H - 1);
    assign in_box = ({1'b0, DrawX} >= x_lo) && ({1'b0, DrawX} <= x_hi) &&
                    ({1'b0, DrawY} >= y_lo) && ({1'b0, DrawY} <= y_hi);
    assign dx     = DrawX - spriteX;
    assign dy     = DrawY - spriteY;

    assign spr_addr = in_box
        ? SHEET_AW'(((32'(dir) * FRAMES_PER_DIR + 32'(frame)) * SPR_H + 32'(dy)) * SPR_W + 32'(dx))
        : '0;

    logic in_box_d, blank_d;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            in_box_d <= 1'b0;
            blank_d  <= 1'b0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else begin
            in_box_d <= in_box;
            blank_d  <= blank;
            if (!blank_d) begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end else if (in_box_d && spr_idx != IDX_W'(TRANSP_IDX)) begin
                red   <= spr_red;
                green <= spr_green;
                blue  <= spr_blue;
            end else begin
                red   <= bg_red;
                green <= bg_green;
                blue  <= bg_blue;
            end
        end
    end

    logic probe_pend, probe_pend2, solid;

    always_comb begin
        solid = 1'b0;
        if (32'(col_idx) < 16)
            solid = SOLID_MASK[col_idx[3:0]];
    end

    // A new frame_start clears the second stage so a stale ROM read never lands.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            col_addr    <= '0;
            probe_pend  <= 1'b0;
            probe_pend2 <= 1'b0;
            collision   <= 1'b0;
        end else begin
            if (frame_start) begin
                col_addr    <= COL_AW'((32'(spriteY) + SPR_H / 2) * SCREEN_W + 32'(spriteX) + SPR_W / 2);
                probe_pend  <= 1'b1;
                probe_pend2 <= 1'b0;
            end else begin
                probe_pend  <= 1'b0;
                probe_pend2 <= probe_pend;
            end
            if (probe_pend2)
                collision <= solid;
        end
    end

endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview:
- Parametrised player-sprite renderer and animator for the VGA pipeline; sits between the VGA controller / ball-motion logic and the colour mapper.
- Selects a facing direction from the keyboard keycode and steps a walk-cycle frame counter on vertical-frame ticks.
- Generates addresses into a single packed sprite-sheet ROM and composites the sprite over the background with index-keyed transparency.
- Probes the collision map once per video frame and reports a registered collision flag.

Parameters:
- SPR_W, 32, sprite width in pixels
- SPR_H, 32, sprite height in pixels
- NUM_DIRS, 4, facing directions stored in the sheet (order: DOWN, UP, LEFT, RIGHT)
- FRAMES_PER_DIR, 2, walk-cycle frames per direction
- FRAME_TICKS, 8, video frames per animation step (>=1)
- IDX_W, 4, sprite palette index width
- TRANSP_IDX, 0, sprite index treated as transparent
- COL_IDX_W, 7, collision-map index width
- SOLID_MASK, 16'h4150, bit i set = collision index i is solid (indices >=16 are never solid)
- SHEET_AW, 13, sprite ROM address width (>= clog2(NUM_DIRS*FRAMES_PER_DIR*SPR_W*SPR_H))
- COL_AW, 18, collision ROM address width

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- DrawX, DrawY  in  10 each  current pixel
- spriteX, spriteY  in  10 each  sprite top-left
- keycode  in  8  USB HID keycode
- blank  in  1  1 = active video
- bg_red, bg_green, bg_blue  in  4 each  background colour, valid 1 cycle after DrawX/DrawY
- spr_addr  out  SHEET_AW  sprite ROM address (combinational)
- spr_idx  in  IDX_W  ROM index, 1-cycle synchronous read
- spr_red, spr_green, spr_blue  in  4 each  palette colour of spr_idx (combinational palette)
- col_addr  out  COL_AW  collision-map probe address (registered)
- col_idx  in  COL_IDX_W  collision-map data, 1-cycle read
- red, green, blue  out  4 each  composited pixel
- collision  out  1  sprite centre is on a solid tile
- anim_dir  out  2  current direction
- anim_frame  out  clog2(FRAMES_PER_DIR)  current frame

Behaviour:
- Reset (reset_n=0 at a vga_clk edge): red/green/blue=0, collision=0, col_addr=0, anim_dir=DOWN, anim_frame=0, tick counter=0, state=IDLE, probe pipe cleared. Reset wins over all other inputs in the same cycle.
- Key decode: 8'h1A=UP, 8'h04=LEFT, 8'h16=DOWN, 8'h07=RIGHT; any other value = no move.
- FSM IDLE:
  - On a move key, go to WALK, load anim_dir, set frame=0 and tick=0.
- FSM WALK:
  - On each frame_start, tick increments. At tick==FRAME_TICKS-1, tick goes to 0 and frame goes to (frame+1) mod FRAMES_PER_DIR.
  - A different move key sets the new dir, frame=0 and tick=0 in the same cycle, with no frame_start needed.
  - No move key returns the FSM to IDLE with frame=0 and the dir retained.
  - Key change coinciding with frame_start: the key change wins; tick=0, not 1.
- Box test uses 11-bit sums so no wrap at 1023:
  - in_box = DrawX in [spriteX, spriteX+SPR_W-1] and DrawY in [spriteY, spriteY+SPR_H-1].
- spr_addr = ((dir*FRAMES_PER_DIR + frame)*SPR_H + (DrawY-spriteY))*SPR_W + (DrawX-spriteX), truncated to SHEET_AW. spr_addr=0 when !in_box.
- Pixel pipeline, total latency 2 cycles from DrawX/DrawY to red/green/blue:
  - Stage 1: in_box and blank are registered alongside the ROM read.
  - Stage 2: output register.
    - !blank_d gives 0.
    - in_box_d && spr_idx!=TRANSP_IDX gives spr_*.
    - Otherwise gives bg_*.
- dir/frame updates may land mid-line; no double-buffering is required.
- Collision probe:
  - On frame_start, col_addr <= (spriteY+SPR_H/2)*640 + (spriteX+SPR_W/2), truncated to COL_AW, and probe_pend is set.
  - The next cycle, probe_pend2 is set (ROM latency).
  - The next cycle, collision <= SOLID_MASK[col_idx] when col_idx<16, else 0.
  - collision holds between probes.
  - A frame_start during a probe in flight restarts the probe.

Decomposition:
- Package sprite_pkg holds:
  - dir_t enum (DIR_DOWN=0, DIR_UP, DIR_LEFT, DIR_RIGHT)
  - anim_state_t (IDLE, WALK)
  - keycode constants KEY_W/A/S/D
  - SCREEN_W=640
- Sub-module sprite_anim_fsm holds the key decode, state, tick and frame counters, with outputs dir and frame. The top holds the address generation, pixel pipeline and collision probe.

Test Plan:
- Reset with keycode=8'h07 held, then release reset_n → first cycle after reset shows anim_dir=DOWN, anim_frame=0, red/green/blue=0, collision=0. The next cycle enters WALK with anim_dir=RIGHT.
- keycode=8'h07, FRAME_TICKS=8, 16 frame_start pulses → anim_frame toggles 0→1 after pulse 8 and 1→0 after pulse 16. Release key → anim_frame=0.
- keycode switches 8'h07→8'h04 on the same cycle as frame_start with tick=7 → anim_dir=LEFT, anim_frame=0, tick=0.
- spriteX=100, spriteY=50, dir=UP (1), frame=1, pixel (105,52):
  - spr_addr=((1*2+1)*32+2)*32+5=3141.
  - With spr_idx=3 and spr_red=F, red=F two cycles later.
  - With spr_idx=0, red=bg_red.
  - At pixel (132,52), output is bg with spr_addr=0.
- spriteX=1000, DrawX=5 → not in_box, no wrap. With blank=0 inside the box → output 0.
- spriteX=100, spriteY=50, frame_start → col_addr=66*640+116=42356. col_idx=6 returns collision=1 two cycles later. col_idx=5 on the next probe returns collision=0. col_idx=20 returns collision=0.
